// File: rtl/memarb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package memarb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Requester identity: 0 = CPU port, 1 = DMA port
  typedef logic port_id_t;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 3;

  // Keeps an out-of-range latency parameter inside the supported window
  function automatic int unsigned clamp_lat(input int unsigned lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single memory port.
// Build option: MEMARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it port 0 has fixed priority with a starvation guard for port 1.
//
// state | meaning
// IDLE  | no transfer; arbitrate and latch the winner's request
// ISSUE | drive latched address/data to memory, MemWr for writes
// WAIT  | extra read latency cycles, address held
// RESP  | one-cycle Ack to the owner, read data presented
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        Wr0,
  input  logic        Wr1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] WData0,
  input  logic [31:0] WData1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [31:0] RData0,
  output logic [31:0] RData1,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  output logic        Busy,
  output logic        Owner
);

  localparam int unsigned LAT = clamp_lat(MEM_LAT);
  // WAIT lasts LAT-1 cycles; the counter is loaded with LAT-2 and exits at zero
  localparam logic [1:0] WAIT_LOAD = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

  state_t      r_state;
  state_t      w_next;
  port_id_t    r_owner;
  port_id_t    w_win;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic [1:0]  r_cnt;
  logic        w_any;

  assign w_any = Req0 | Req1;

`ifdef MEMARB_ROUND_ROBIN_EN
  function automatic port_id_t arbitrate(input logic req0, input logic req1,
                                         input port_id_t owner);
    if (req0 && req1) return ~owner;
    return req1;
  endfunction

  // Contention goes to the port that did not win last time
  always_comb w_win = arbitrate(Req0, Req1, r_owner);
`else
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_starve;
  logic          w_starve_hit;

  assign w_starve_hit = (r_starve == SW'(STARVE_MAX));

  function automatic port_id_t arbitrate(input logic req0, input logic req1,
                                         input logic starve_hit);
    if (req0 && req1) return starve_hit;
    return req1;
  endfunction

  // Port 0 wins contention unless port 1 has lost STARVE_MAX times in a row
  always_comb w_win = arbitrate(Req0, Req1, w_starve_hit);

  // Count contended losses of port 1 (saturating); any port 1 grant clears it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (r_state == IDLE && w_any) begin
      if (w_win) r_starve <= '0;
      else if (Req1 && !w_starve_hit) r_starve <= r_starve + SW'(1);
    end
  end
`endif

  // State register; reset forces IDLE so MemWr/Ack/Busy drop immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and state-derived handshake outputs
  always_comb begin
    w_next = r_state;
    MemWr  = 1'b0;
    Ack0   = 1'b0;
    Ack1   = 1'b0;
    Busy   = 1'b1;
    case (r_state)
      IDLE: begin
        Busy = 1'b0;
        if (w_any) w_next = ISSUE;
      end
      ISSUE: begin
        MemWr  = r_wr;
        w_next = (r_wr || LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (r_cnt == 2'd0) w_next = RESP;
      end
      RESP: begin
        Ack0   = ~r_owner;
        Ack1   = r_owner;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the winner's request, run the wait countdown, capture read data on RESP entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner  <= 1'b1;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= 2'd0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_owner <= w_win;
        r_wr    <= w_win ? Wr1    : Wr0;
        r_addr  <= w_win ? Addr1  : Addr0;
        r_wdata <= w_win ? WData1 : WData0;
      end
      if (r_state == ISSUE && w_next == WAIT) r_cnt <= WAIT_LOAD;
      else if (r_state == WAIT && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
      if (w_next == RESP && !r_wr) begin
        if (r_owner) r_rdata1 <= MemRData;
        else         r_rdata0 <= MemRData;
      end
    end
  end

  assign MemAddr  = r_addr;
  assign MemWData = r_wdata;
  assign RData0   = r_rdata0;
  assign RData1   = r_rdata1;
  assign Owner    = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1/STARVE_MAX=8 and
// MEM_LAT=3/STARVE_MAX=2) share stimulus; sel picks the one being checked.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [31:0] mem_rdata;
  logic        sel;

  logic        a_ack0, a_ack1, a_mwr, a_busy, a_owner;
  logic [31:0] a_rd0, a_rd1, a_maddr, a_mwd;
  logic        b_ack0, b_ack1, b_mwr, b_busy, b_owner;
  logic [31:0] b_rd0, b_rd1, b_maddr, b_mwd;

  logic        obs_ack0, obs_ack1, obs_mwr, obs_busy, obs_owner;
  logic [31:0] obs_rd0, obs_rd1, obs_maddr, obs_mwd;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_rd0, exp_rd1;
  int          mem_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(8)) u_dut_a (
    .clock(clk), .reset(rst_n), .Req0(req0), .Req1(req1), .Wr0(wr0), .Wr1(wr1),
    .Addr0(addr0), .Addr1(addr1), .WData0(wdata0), .WData1(wdata1),
    .Ack0(a_ack0), .Ack1(a_ack1), .RData0(a_rd0), .RData1(a_rd1),
    .MemAddr(a_maddr), .MemWr(a_mwr), .MemWData(a_mwd), .MemRData(mem_rdata),
    .Busy(a_busy), .Owner(a_owner));

  mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(2)) u_dut_b (
    .clock(clk), .reset(rst_n), .Req0(req0), .Req1(req1), .Wr0(wr0), .Wr1(wr1),
    .Addr0(addr0), .Addr1(addr1), .WData0(wdata0), .WData1(wdata1),
    .Ack0(b_ack0), .Ack1(b_ack1), .RData0(b_rd0), .RData1(b_rd1),
    .MemAddr(b_maddr), .MemWr(b_mwr), .MemWData(b_mwd), .MemRData(mem_rdata),
    .Busy(b_busy), .Owner(b_owner));

  always_comb begin
    obs_ack0  = sel ? b_ack0  : a_ack0;
    obs_ack1  = sel ? b_ack1  : a_ack1;
    obs_mwr   = sel ? b_mwr   : a_mwr;
    obs_busy  = sel ? b_busy  : a_busy;
    obs_owner = sel ? b_owner : a_owner;
    obs_rd0   = sel ? b_rd0   : a_rd0;
    obs_rd1   = sel ? b_rd1   : a_rd1;
    obs_maddr = sel ? b_maddr : a_maddr;
    obs_mwd   = sel ? b_mwd   : a_mwd;
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Memory model: data is valid only in the MEM_LAT-th busy cycle (ISSUE counts as 1)
  always @(posedge clk) mem_cnt <= obs_busy ? mem_cnt + 1 : 1;

  always_comb begin
    if (mem_cnt == (sel ? 3 : 1)) mem_rdata = mem_f(obs_maddr);
    else                          mem_rdata = 32'hBAD00000 | (32'(mem_cnt) & 32'hFFFF);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("rst_memwr", 32'(obs_mwr), 32'd0);
    check("rst_busy",  32'(obs_busy), 32'd0);
    check("rst_ack0",  32'(obs_ack0), 32'd0);
    check("rst_ack1",  32'(obs_ack1), 32'd0);
    check("rst_owner", 32'(obs_owner), 32'd1);
    check("rst_maddr", obs_maddr, 32'd0);
    check("rst_mwd",   obs_mwd, 32'd0);
    check("rst_rd0",   obs_rd0, 32'd0);
    check("rst_rd1",   obs_rd1, 32'd0);
    exp_rd0 = '0; exp_rd1 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated transfer; expectations follow the latency rules directly
  task automatic single(input bit port, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat);
    int len;
    len = wr ? 2 : lat + 1;
    @(negedge clk);
    if (port) begin req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = wdata; end
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      check("s_busy",  32'(obs_busy), 32'd1);
      check("s_memwr", 32'(obs_mwr), 32'(k == 1 && wr));
      check("s_ack0",  32'(obs_ack0), 32'(k == len && !port));
      check("s_ack1",  32'(obs_ack1), 32'(k == len && port));
      if (k < len) check("s_maddr", obs_maddr, addr);
      if (k == 1 && wr) check("s_mwdata", obs_mwd, wdata);
      if (k == len) begin
        if (port) req1 = 1'b0; else req0 = 1'b0;
        if (!wr) begin
          if (port) exp_rd1 = mem_f(addr); else exp_rd0 = mem_f(addr);
        end
        check("s_rd0", obs_rd0, exp_rd0);
        check("s_rd1", obs_rd1, exp_rd1);
      end
    end
    @(negedge clk);
    check("s_idle",  32'(obs_busy), 32'd0);
    check("s_owner", 32'(obs_owner), 32'(port));
  endtask

  // Reset asserted while a port 1 write is in ISSUE
  task automatic reset_mid_write();
    @(negedge clk);
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h44; wdata1 = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("r_memwr_pre", 32'(obs_mwr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("r_memwr",  32'(obs_mwr), 32'd0);
    check("r_busy",   32'(obs_busy), 32'd0);
    check("r_ack1",   32'(obs_ack1), 32'd0);
    check("r_maddr",  obs_maddr, 32'd0);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rd0 = '0; exp_rd1 = '0;
    repeat (3) begin
      @(negedge clk);
      check("r_noack1", 32'(obs_ack1), 32'd0);
      check("r_idle",   32'(obs_busy), 32'd0);
      check("r_owner",  32'(obs_owner), 32'd1);
    end
  endtask

  // Transaction-level reference run; must start right after a reset release
  task automatic run_model(input int ncyc, input bit cont, input int lat, input int smax);
    bit          pend [2];
    bit          f_wr [2];
    logic [31:0] f_addr [2];
    logic [31:0] f_wd [2];
    int          m_age, m_len, m_starve;
    bit          m_owner, m_wr, win, both;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] erd0, erd1;
    bit          gq [$];
    m_age = 0; m_len = 2; m_starve = 0; m_owner = 1'b1; m_wr = 1'b0;
    m_addr = '0; m_wdata = '0; erd0 = '0; erd1 = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check("m_busy",  32'(obs_busy), 32'(m_age != 0));
      check("m_ack0",  32'(obs_ack0), 32'(m_age != 0 && m_age == m_len && !m_owner));
      check("m_ack1",  32'(obs_ack1), 32'(m_age != 0 && m_age == m_len && m_owner));
      check("m_memwr", 32'(obs_mwr), 32'(m_age == 1 && m_wr));
      check("m_owner", 32'(obs_owner), 32'(m_owner));
      check("m_rd0",   obs_rd0, erd0);
      check("m_rd1",   obs_rd1, erd1);
      if (m_age != 0 && m_age < m_len) check("m_maddr", obs_maddr, m_addr);
      if (m_age == 1 && m_wr) check("m_mwdata", obs_mwd, m_wdata);
      if (obs_ack0) gq.push_back(1'b0);
      if (obs_ack1) gq.push_back(1'b1);
      // requesters: retire on the model's ack, maybe re-request in the same cycle
      if (m_age != 0 && m_age == m_len) pend[m_owner] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          f_wr[p] = 1'($urandom_range(0, 1));
          f_addr[p] = $urandom;
          f_wd[p] = $urandom;
          if (cont || $urandom_range(0, 99) < 35) pend[p] = 1'b1;
        end
      end
      req0 = pend[0]; wr0 = f_wr[0]; addr0 = f_addr[0]; wdata0 = f_wd[0];
      req1 = pend[1]; wr1 = f_wr[1]; addr1 = f_addr[1]; wdata1 = f_wd[1];
      // advance the reference across the coming rising edge
      if (m_age == 0) begin
        if (pend[0] || pend[1]) begin
          both = pend[0] && pend[1];
`ifdef MEMARB_ROUND_ROBIN_EN
          win = both ? !m_owner : pend[1];
`else
          win = both ? (m_starve == smax) : pend[1];
          if (win) m_starve = 0;
          else if (both && m_starve < smax) m_starve++;
`endif
          m_owner = win; m_wr = f_wr[win]; m_addr = f_addr[win]; m_wdata = f_wd[win];
          m_len = m_wr ? 2 : lat + 1;
          m_age = 1;
        end
      end else if (m_age == m_len) begin
        m_age = 0;
      end else begin
        m_age++;
        if (m_age == m_len && !m_wr) begin
          if (m_owner) erd1 = mem_f(m_addr); else erd0 = mem_f(m_addr);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    if (cont) begin
      check("g_count", 32'(gq.size() >= 12), 32'd1);
      for (int k = 0; k < gq.size(); k++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
        check("g_pattern", 32'(gq[k]), 32'(k % 2));
`else
        check("g_pattern", 32'(gq[k]), 32'((k % (smax + 1)) == smax));
`endif
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    exp_rd0 = '0; exp_rd1 = '0;

    do_reset();
    single(1'b0, 1'b0, 32'h10, 32'h0, 1);
    single(1'b1, 1'b1, 32'h20, 32'h12345678, 1);
    single(1'b1, 1'b0, 32'h80, 32'h0, 1);
    reset_mid_write();

    sel = 1'b1;
    do_reset();
    single(1'b0, 1'b0, 32'h100, 32'h0, 3);
    single(1'b1, 1'b1, 32'h104, 32'hA5A55A5A, 3);
    single(1'b1, 1'b0, 32'h10, 32'h0, 3);

    sel = 1'b0;
    do_reset();
    run_model(120, 1'b1, 1, 8);
    do_reset();
    run_model(800, 1'b0, 1, 8);

    sel = 1'b1;
    do_reset();
    run_model(150, 1'b1, 3, 2);
    do_reset();
    run_model(800, 1'b0, 3, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: memory read latency in cycles from address issue to valid MemRData; legal range 1..3.
REQ-002 Parameter STARVE_MAX, default 8: consecutive lost arbitrations after which port 1 is forced to win.
REQ-003 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Ports: Req0/Req1  in  1  transfer request, port 0 (CPU) and port 1 (DMA).
REQ-006 Ports: Wr0/Wr1  in  1  1 = write, 0 = read.
REQ-007 Ports: Addr0/Addr1  in  32  byte address.
REQ-008 Ports: WData0/WData1  in  32  write data.
REQ-009 Ports: Ack0/Ack1  out  1  one-cycle completion pulse.
REQ-010 Ports: RData0/RData1  out  32  registered read data, valid while AckN=1.
REQ-011 Ports: MemAddr  out  32; MemWr  out  1; MemWData  out  32  shared memory port.
REQ-012 Port: MemRData  in  32  memory read data.
REQ-013 Ports: Busy  out  1  high outside IDLE; Owner  out  1  port currently or last granted.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: with no request, remain in IDLE; with any ReqN=1, latch winner into Owner, register its Addr/Wr/WData, go to ISSUE.
REQ-016 ISSUE (one cycle): MemAddr/MemWData driven from latched values; MemWr=1 only for a write; a write goes to RESP; a read goes to WAIT if MEM_LAT>1, otherwise to RESP.
REQ-017 WAIT: held for MEM_LAT-1 cycles by a down-counter; MemAddr held stable; MemWr=0.
REQ-018 RESP (one cycle): Ack[Owner]=1; for a read, RData[Owner] holds MemRData captured on the RESP entry edge; next state IDLE.
REQ-019 Latency from Req sampled in IDLE to Ack: write 2 cycles; read MEM_LAT+1 cycles.
REQ-020 MemWr SHALL be 0 in every state except ISSUE with a latched write.
REQ-021 Requester SHALL hold Req/Wr/Addr/WData stable until Ack; changes after the IDLE sample are ignored.
REQ-022 Req still high in the Ack cycle is a new request, arbitrated in the following IDLE cycle.
REQ-023 The non-owner Ack SHALL stay 0; RDataN of the non-owner retains its prior value.
REQ-024 Fixed priority (macro absent): port 0 wins contention unless the starvation counter equals STARVE_MAX, then port 1 wins.
REQ-025 The starvation counter increments when port 1 loses a contended arbitration, clears when port 1 is granted, and saturates at STARVE_MAX.
REQ-026 Simultaneous reset and transfer: reset wins; the in-flight transfer is dropped with no Ack.

Reset
REQ-027 While reset=0: state IDLE; Ack0/Ack1, MemWr, Busy=0; MemAddr, MemWData, RData0/RData1=0; Owner=1; counters=0.
REQ-028 MemWr SHALL go low asynchronously on reset assertion, including mid-ISSUE.
REQ-029 First arbitration after reset behaves as in REQ-024/REQ-031 with Owner=1.

Configuration
REQ-030 Macro MEMARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-031 Defined: on contention, the port not equal to Owner wins; the starvation counter is not built and STARVE_MAX is ignored.
REQ-032 Undefined: fixed priority with starvation guard per REQ-024/REQ-025.
REQ-033 An uncontested request wins in both builds.

Structure
REQ-034 Package memarb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, RESP), the port-id typedef, and the MEM_LAT legal-range constants.
REQ-035 Single module; no sub-module; arbitration is a combinational function inside mem_arbiter.

Verification
REQ-036 Port 0 read Addr0=0x00000010, MEM_LAT=1, MemRData=0xDEADBEEF -> MemAddr=0x10 in ISSUE, Ack0 two cycles after the sample, RData0=0xDEADBEEF.
REQ-037 Port 1 write Addr1=0x20, WData1=0x12345678 -> exactly one cycle of MemWr=1 with MemAddr=0x20, Ack1 on the next cycle.
REQ-038 Both requesting continuously, fixed priority, STARVE_MAX=8 -> 8 port-0 grants, then one port-1 grant, then the pattern repeats.
REQ-039 MEMARB_ROUND_ROBIN_EN defined, both requesting continuously -> first grant port 0, then grants alternate 1,0,1.
REQ-040 MEM_LAT=3 read -> 2 WAIT cycles, Ack 4 cycles after the sample, Busy high for 4 cycles.
REQ-041 reset=0 asserted during an ISSUE write -> MemWr drops immediately, no Ack, IDLE after release.
